// File: rtl/sprite_pkg.sv
// Shared sizes, sprite-table entry type and the lowest-set-bit isolator used
// by sprite_select_gen and its per-sprite comparator.
package sprite_pkg;
  localparam int NUM_SPRITES = 16;
  localparam int COORD_W     = 10;
  localparam int SPR_DIM     = 32;
  localparam int OFS_W       = $clog2(SPR_DIM);
  localparam int IDX_W       = $clog2(NUM_SPRITES);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sprite_entry_t;

  // Two's-complement trick: v & -v keeps only the lowest set bit.
  function automatic logic [NUM_SPRITES-1:0] lowest_set(input logic [NUM_SPRITES-1:0] v);
    return v & (~v + NUM_SPRITES'(1));
  endfunction
endpackage

// File: rtl/sprite_box_cmp.sv
// Single-sprite bounding-box test: hit plus x/y offset of the pixel inside the box.
module sprite_box_cmp
  import sprite_pkg::*;
(
  input  logic               ent_en,
  input  logic [COORD_W-1:0] ent_x,
  input  logic [COORD_W-1:0] ent_y,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic               hit,
  output logic [OFS_W-1:0]   x_ofs,
  output logic [OFS_W-1:0]   y_ofs
);
  logic [COORD_W:0]   x_end, y_end;
  logic [COORD_W-1:0] dx, dy;
  logic               in_x, in_y;

  // One extra bit on the far edge so boxes near the right/bottom never wrap to 0.
  assign x_end = {1'b0, ent_x} + (COORD_W+1)'(SPR_DIM);
  assign y_end = {1'b0, ent_y} + (COORD_W+1)'(SPR_DIM);
  assign in_x  = (pix_x >= ent_x) && ({1'b0, pix_x} < x_end);
  assign in_y  = (pix_y >= ent_y) && ({1'b0, pix_y} < y_end);
  assign hit   = ent_en && in_x && in_y;

  assign dx    = pix_x - ent_x;
  assign dy    = pix_y - ent_y;
  assign x_ofs = dx[OFS_W-1:0];
  assign y_ofs = dy[OFS_W-1:0];
endmodule

// File: rtl/sprite_select_gen.sv
// Per-pixel sprite selector: 16 box tests, lowest-index priority, one-hot sel
// and in-sprite offsets, two registered stages. SPRITE_COLLIDE_EN adds a
// sticky multi-hit collision flag.
module sprite_select_gen
  import sprite_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic                   cfg_en,
  input  logic [COORD_W-1:0]     cfg_x,
  input  logic [COORD_W-1:0]     cfg_y,
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     pix_x,
  input  logic [COORD_W-1:0]     pix_y,
  input  logic                   stall,
`ifdef SPRITE_COLLIDE_EN
  input  logic                   collide_clr,
  output logic                   collide,
`endif
  output logic [NUM_SPRITES-1:0] sel,
  output logic                   hit,
  output logic [OFS_W-1:0]       row_ofs,
  output logic [OFS_W-1:0]       col_ofs,
  output logic                   out_valid
);
  localparam int STAGES = 2;

  sprite_entry_t tbl_q [NUM_SPRITES];
  sprite_entry_t tbl_d [NUM_SPRITES];

  logic [NUM_SPRITES-1:0]            cmp_hit;
  logic [NUM_SPRITES-1:0][OFS_W-1:0] cmp_xofs, cmp_yofs;

  logic [NUM_SPRITES-1:0]            hit_vec_q, hit_vec_d;
  logic [NUM_SPRITES-1:0][OFS_W-1:0] xofs_q, xofs_d, yofs_q, yofs_d;
  logic [STAGES:1]                   vld_pipe_q, vld_pipe_d;

  logic [NUM_SPRITES-1:0]            iso, sel_q, sel_d;
  logic                              hit_q, hit_d;
  logic [OFS_W-1:0]                  row_pick, col_pick;
  logic [OFS_W-1:0]                  row_ofs_q, row_ofs_d, col_ofs_q, col_ofs_d;
`ifdef SPRITE_COLLIDE_EN
  logic                              multi_q, multi_d, collide_q, collide_d;
`endif

  // Table writes ignore stall; stage 1 already captured its own hit results.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we) tbl_d[cfg_idx] = '{en: cfg_en, x: cfg_x, y: cfg_y};
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_cmp
    sprite_box_cmp u_cmp (
      .ent_en (tbl_q[i].en),
      .ent_x  (tbl_q[i].x),
      .ent_y  (tbl_q[i].y),
      .pix_x  (pix_x),
      .pix_y  (pix_y),
      .hit    (cmp_hit[i]),
      .x_ofs  (cmp_xofs[i]),
      .y_ofs  (cmp_yofs[i])
    );
  end

  // iso is one-hot or zero, so OR-ing masked offsets acts as a mux.
  always_comb begin
    iso      = lowest_set(hit_vec_q);
    row_pick = '0;
    col_pick = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (iso[i]) begin
        row_pick = row_pick | yofs_q[i];
        col_pick = col_pick | xofs_q[i];
      end
    end
  end

  always_comb begin
    hit_vec_d  = hit_vec_q;
    xofs_d     = xofs_q;
    yofs_d     = yofs_q;
    vld_pipe_d = vld_pipe_q;
    sel_d      = sel_q;
    hit_d      = hit_q;
    row_ofs_d  = row_ofs_q;
    col_ofs_d  = col_ofs_q;
`ifdef SPRITE_COLLIDE_EN
    multi_d    = multi_q;
`endif
    if (!stall) begin
      hit_vec_d  = cmp_hit;
      xofs_d     = cmp_xofs;
      yofs_d     = cmp_yofs;
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], pix_valid};
      sel_d      = vld_pipe_q[1] ? iso : '0;
      hit_d      = vld_pipe_q[1] & (|hit_vec_q);
      row_ofs_d  = vld_pipe_q[1] ? row_pick : '0;
      col_ofs_d  = vld_pipe_q[1] ? col_pick : '0;
`ifdef SPRITE_COLLIDE_EN
      // popcount >= 2 is the same as a hit surviving removal of the lowest one.
      multi_d    = vld_pipe_q[1] & (|(hit_vec_q & ~iso));
`endif
    end
  end

`ifdef SPRITE_COLLIDE_EN
  // Set has priority over clear when both land on the same edge.
  always_comb begin
    collide_d = (collide_q & ~collide_clr) | (~stall & vld_pipe_q[STAGES] & multi_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) tbl_q[i] <= '0;
      hit_vec_q  <= '0;
      xofs_q     <= '0;
      yofs_q     <= '0;
      vld_pipe_q <= '0;
      sel_q      <= '0;
      hit_q      <= 1'b0;
      row_ofs_q  <= '0;
      col_ofs_q  <= '0;
`ifdef SPRITE_COLLIDE_EN
      multi_q    <= 1'b0;
      collide_q  <= 1'b0;
`endif
    end else begin
      tbl_q      <= tbl_d;
      hit_vec_q  <= hit_vec_d;
      xofs_q     <= xofs_d;
      yofs_q     <= yofs_d;
      vld_pipe_q <= vld_pipe_d;
      sel_q      <= sel_d;
      hit_q      <= hit_d;
      row_ofs_q  <= row_ofs_d;
      col_ofs_q  <= col_ofs_d;
`ifdef SPRITE_COLLIDE_EN
      multi_q    <= multi_d;
      collide_q  <= collide_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign hit       = hit_q;
  assign row_ofs   = row_ofs_q;
  assign col_ofs   = col_ofs_q;
  assign out_valid = vld_pipe_q[STAGES];
`ifdef SPRITE_COLLIDE_EN
  assign collide   = collide_q;
`endif
endmodule

// File: tb/tb_sprite_select_gen.sv
// Scoreboard bench for sprite_select_gen: a behavioural sprite-table model
// predicts each pixel's result; DUT outputs are queued and compared in order.
module tb_sprite_select_gen;
  logic        clk = 1'b0;
  logic        rst_n, cfg_we, cfg_en, pix_valid, stall;
  logic [3:0]  cfg_idx;
  logic [9:0]  cfg_x, cfg_y, pix_x, pix_y;
  logic [15:0] sel;
  logic        hit, out_valid;
  logic [4:0]  row_ofs, col_ofs;
`ifdef SPRITE_COLLIDE_EN
  logic        collide, collide_clr;
`endif

  always #5 clk = ~clk;

  sprite_select_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .stall(stall),
`ifdef SPRITE_COLLIDE_EN
    .collide_clr(collide_clr), .collide(collide),
`endif
    .sel(sel), .hit(hit), .row_ofs(row_ofs), .col_ofs(col_ofs), .out_valid(out_valid)
  );

  typedef logic [26:0] res_t;  // {hit, sel, row_ofs, col_ofs}
  int   n_chk = 0, n_pass = 0;
  logic       m_en [16];
  logic [9:0] m_x  [16];
  logic [9:0] m_y  [16];
  res_t exp_q[$], obs_q[$];

  // Scan from the top so the last match kept is the lowest index.
  function automatic res_t model(input logic [9:0] px, input logic [9:0] py);
    res_t r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m_en[i] && int'(px) >= int'(m_x[i]) && int'(px) < int'(m_x[i]) + 32 &&
          int'(py) >= int'(m_y[i]) && int'(py) < int'(m_y[i]) + 32)
        r = {1'b1, 16'(32'd1 << i), 5'(py - m_y[i]), 5'(px - m_x[i])};
    end
    return r;
  endfunction

  task automatic cyc(input logic rst, input logic pv, input logic [9:0] px, input logic [9:0] py,
                     input logic we, input logic [3:0] idx, input logic en,
                     input logic [9:0] x, input logic [9:0] y, input logic st);
    rst_n = rst; pix_valid = pv; pix_x = px; pix_y = py;
    cfg_we = we; cfg_idx = idx; cfg_en = en; cfg_x = x; cfg_y = y; stall = st;
    if (rst && pv && !st) exp_q.push_back(model(px, py));
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin m_en[i] = 1'b0; m_x[i] = '0; m_y[i] = '0; end
    end else if (we) begin
      m_en[idx] = en; m_x[idx] = x; m_y[idx] = y;
    end
    @(posedge clk); #1;
    if (rst && !st && out_valid) obs_q.push_back({hit, sel, row_ofs, col_ofs});
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py);
    cyc(1'b1, 1'b1, px, py, 1'b0, 4'd0, 1'b0, 10'd0, 10'd0, 1'b0);
  endtask
  task automatic idle();
    cyc(1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 4'd0, 1'b0, 10'd0, 10'd0, 1'b0);
  endtask
  task automatic wr(input logic [3:0] idx, input logic en, input logic [9:0] x, input logic [9:0] y);
    cyc(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, idx, en, x, y, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 4'd0, 1'b0, 10'd0, 10'd0, 1'b0);
    cyc(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 4'd0, 1'b0, 10'd0, 10'd0, 1'b0);
    n_chk++;
    if ({out_valid, hit, sel, row_ofs, col_ofs} !== 28'h0)
      $display("FAIL reset_state: got %h want 0", {out_valid, hit, sel, row_ofs, col_ofs});
    else n_pass++;
  endtask

  task automatic test_single_hit();
    wr(4'd3, 1'b1, 10'd100, 10'd50);
    idle();
    pix(10'd110, 10'd60);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL single_latency_early: out_valid %b want 0", out_valid);
    else n_pass++;
    idle();
    n_chk++;
    if ({out_valid, hit, sel, row_ofs, col_ofs} !== {1'b1, 1'b1, 16'h0008, 5'd10, 5'd10})
      $display("FAIL single_hit: got v%b h%b sel %h r%0d c%0d want v1 h1 sel 0008 r10 c10",
               out_valid, hit, sel, row_ofs, col_ofs);
    else n_pass++;
    repeat (2) idle();
    while (exp_q.size() > 0) begin
      res_t e, o;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL single_sb: no output, want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL single_sb: got %h want %h", o, e); else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL single_sb: %0d extra outputs want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_overlap();
    wr(4'd2, 1'b1, 10'd0, 10'd0);
    wr(4'd9, 1'b1, 10'd8, 10'd8);
    pix(10'd10, 10'd10);
    idle();
    n_chk++;
    if ({hit, sel, row_ofs, col_ofs} !== {1'b1, 16'h0004, 5'd10, 5'd10})
      $display("FAIL overlap_prio: got h%b sel %h r%0d c%0d want h1 sel 0004 r10 c10",
               hit, sel, row_ofs, col_ofs);
    else n_pass++;
    pix(10'd35, 10'd20);
    pix(10'd20, 10'd35);
    pix(10'd40, 10'd40);
    pix(10'd39, 10'd39);
    repeat (3) idle();
    while (exp_q.size() > 0) begin
      res_t e, o;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL overlap_sb: no output, want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL overlap_sb: got %h want %h", o, e); else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL overlap_sb: %0d extra outputs want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_edges();
    wr(4'd0, 1'b1, 10'd200, 10'd200);
    wr(4'd1, 1'b1, 10'd1000, 10'd290);
    wr(4'd4, 1'b1, 10'd1020, 10'd290);
    pix(10'd231, 10'd231);
    pix(10'd232, 10'd200);
    pix(10'd200, 10'd232);
    pix(10'd199, 10'd215);
    pix(10'd200, 10'd200);
    pix(10'd5,   10'd300);
    pix(10'd3,   10'd300);
    pix(10'd1023, 10'd300);
    pix(10'd1021, 10'd321);
    pix(10'd1021, 10'd322);
    repeat (3) idle();
    while (exp_q.size() > 0) begin
      res_t e, o;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL edges_sb: no output, want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL edges_sb: got %h want %h", o, e); else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL edges_sb: %0d extra outputs want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_write_collision();
    wr(4'd3, 1'b1, 10'd100, 10'd50);
    cyc(1'b1, 1'b1, 10'd110, 10'd60, 1'b1, 4'd3, 1'b0, 10'd100, 10'd50, 1'b0);
    pix(10'd110, 10'd60);
    n_chk++;
    if (sel !== 16'h0008) $display("FAIL wcol_old_table: sel %h want 0008", sel); else n_pass++;
    idle();
    n_chk++;
    if ({out_valid, sel} !== {1'b1, 16'h0000})
      $display("FAIL wcol_new_table: v%b sel %h want v1 sel 0000", out_valid, sel);
    else n_pass++;
    repeat (2) idle();
    while (exp_q.size() > 0) begin
      res_t e, o;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL wcol_sb: no output, want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL wcol_sb: got %h want %h", o, e); else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL wcol_sb: %0d extra outputs want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [27:0] snap;
    pix(10'd10, 10'd10);
    pix(10'd20, 10'd20);
    pix(10'd35, 10'd35);
    snap = {out_valid, hit, sel, row_ofs, col_ofs};
    // Write sprite 5 during the stall; the stalled pixel inputs must be ignored.
    cyc(1'b1, 1'b1, 10'd500, 10'd500, 1'b1, 4'd5, 1'b1, 10'd490, 10'd490, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc(1'b1, 1'b1, 10'd500, 10'd500, 1'b0, 4'd0, 1'b0, 10'd0, 10'd0, 1'b1);
      n_chk++;
      if ({out_valid, hit, sel, row_ofs, col_ofs} !== snap)
        $display("FAIL stall_frozen: cycle %0d got %h want %h", k,
                 {out_valid, hit, sel, row_ofs, col_ofs}, snap);
      else n_pass++;
    end
    pix(10'd495, 10'd495);
    pix(10'd12, 10'd12);
    pix(10'd30, 10'd30);
    repeat (3) idle();
    while (exp_q.size() > 0) begin
      res_t e, o;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL stall_sb: no output, want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL stall_sb: got %h want %h", o, e); else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL stall_sb: %0d extra outputs want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 80; k++) begin
      logic       we  = ($urandom_range(0, 3) == 0);
      logic [3:0] idx = 4'($urandom_range(0, 15));
      logic       en  = ($urandom_range(0, 3) != 0);
      logic [9:0] x   = 10'($urandom_range(0, 150));
      logic [9:0] y   = 10'($urandom_range(0, 150));
      logic       pv  = ($urandom_range(0, 3) != 0);
      logic [9:0] px  = 10'($urandom_range(0, 190));
      logic [9:0] py  = 10'($urandom_range(0, 190));
      logic       st  = ($urandom_range(0, 6) == 0);
      cyc(1'b1, pv, px, py, we, idx, en, x, y, st);
    end
    repeat (3) idle();
    while (exp_q.size() > 0) begin
      res_t e, o;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL b2b_sb: no output, want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_sb: got %h want %h", o, e); else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL b2b_sb: %0d extra outputs want 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    wr(4'd3, 1'b1, 10'd100, 10'd50);
    wr(4'd3, 1'b1, 10'd105, 10'd55);
    pix(10'd110, 10'd60);
    pix(10'd111, 10'd61);
    cyc(1'b0, 1'b1, 10'd112, 10'd62, 1'b1, 4'd3, 1'b1, 10'd100, 10'd50, 1'b1);
    n_chk++;
    if ({out_valid, sel} !== 17'h0)
      $display("FAIL reset_mid: v%b sel %h want v0 sel 0000", out_valid, sel);
    else n_pass++;
    exp_q.delete();
    obs_q.delete();
    pix(10'd110, 10'd60);
    pix(10'd10, 10'd10);
    pix(10'd205, 10'd205);
    repeat (3) idle();
    while (exp_q.size() > 0) begin
      res_t e, o;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL reset_sb: no output, want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL reset_sb: got %h want %h", o, e); else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL reset_sb: %0d extra outputs want 0", obs_q.size());
    else n_pass++;
  endtask

`ifdef SPRITE_COLLIDE_EN
  task automatic test_collide();
    wr(4'd2, 1'b1, 10'd0, 10'd0);
    wr(4'd9, 1'b1, 10'd8, 10'd8);
    pix(10'd2, 10'd2);
    repeat (3) idle();
    n_chk++;
    if (collide !== 1'b0) $display("FAIL collide_single: got %b want 0", collide); else n_pass++;
    pix(10'd10, 10'd10);
    idle();
    n_chk++;
    if (collide !== 1'b0) $display("FAIL collide_early: got %b want 0", collide); else n_pass++;
    idle();
    n_chk++;
    if (collide !== 1'b1) $display("FAIL collide_set: got %b want 1", collide); else n_pass++;
    repeat (2) idle();
    n_chk++;
    if (collide !== 1'b1) $display("FAIL collide_sticky: got %b want 1", collide); else n_pass++;
    collide_clr = 1'b1;
    idle();
    collide_clr = 1'b0;
    n_chk++;
    if (collide !== 1'b0) $display("FAIL collide_clr: got %b want 0", collide); else n_pass++;
    pix(10'd10, 10'd10);
    idle();
    collide_clr = 1'b1;
    idle();
    collide_clr = 1'b0;
    n_chk++;
    if (collide !== 1'b1) $display("FAIL collide_set_wins: got %b want 1", collide); else n_pass++;
    exp_q.delete();
    obs_q.delete();
  endtask
`endif

  initial begin
`ifdef SPRITE_COLLIDE_EN
    collide_clr = 1'b0;
`endif
    test_reset();
    test_single_hit();
    test_overlap();
    test_edges();
    test_write_collision();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
`ifdef SPRITE_COLLIDE_EN
    test_collide();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
